// File: rtl/md_defs.sv
// Shared definitions for the multiply/divide sequencer: op and state encodings,
// counter width and a helper that classifies multi-cycle ops.
package md_defs;

  localparam int unsigned MD_CNT_W = 4;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: 64-bit products, quotient/remainder
// with MIPS semantics, and a divide-by-zero flag for the sequencer.
module md_arith
  import md_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;
  logic               div_ovf;
  logic               b_zero;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    quot_s      = '0;
    rem_s       = '0;
    quot_u      = '0;
    rem_u       = '0;
    res_hi      = '0;
    res_lo      = '0;
    div_by_zero = 1'b0;

    b_zero  = (b == 32'd0);
    div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u  = {32'd0, a} * {32'd0, b};

    // The most-negative / -1 case is pinned explicitly rather than left to the divider.
    if (div_ovf) begin
      quot_s = 32'sh8000_0000;
      rem_s  = 32'sd0;
    end else if (!b_zero) begin
      quot_s = $signed(a) / $signed(b);
      rem_s  = $signed(a) % $signed(b);
    end
    if (!b_zero) begin
      quot_u = a / b;
      rem_u  = a % b;
    end

    case (op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        res_hi = rem_s;
        res_lo = quot_s;
      end
      MD_DIVU: begin
        res_hi = rem_u;
        res_lo = quot_u;
      end
      default: ;
    endcase

    if (md_is_div(op)) div_by_zero = b_zero;
  end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO owner for the MIPS pipeline: latches MD results at issue, models their
// latency with a busy counter, and requests stalls while results are in flight.
module md_sequencer
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        md_use,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [MD_CNT_W-1:0] MULT_LAST = MD_CNT_W'(MULT_CYCLES - 1);
  localparam logic [MD_CNT_W-1:0] DIV_LAST  = MD_CNT_W'(DIV_CYCLES - 1);

  md_state_e           state_q;
  logic [MD_CNT_W-1:0] cnt_q;
  logic [31:0]         pend_hi_q;
  logic [31:0]         pend_lo_q;
  logic                pend_dbz_q;
  logic [31:0]         hi_q;
  logic [31:0]         lo_q;

  logic [31:0]         res_hi_d;
  logic [31:0]         res_lo_d;
  logic                dbz_d;
  logic                go;

  md_arith u_arith (
    .op          (op),
    .a           (a),
    .b           (b),
    .res_hi      (res_hi_d),
    .res_lo      (res_lo_d),
    .div_by_zero (dbz_d)
  );

  // A cancelled E-stage op, or one issued while RUN, must leave no trace.
  assign go = start & ~flush & (state_q == MD_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      pend_hi_q  <= '0;
      pend_lo_q  <= '0;
      pend_dbz_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (go) begin
            case (op)
              MD_MULT, MD_MULTU: begin
                pend_hi_q  <= res_hi_d;
                pend_lo_q  <= res_lo_d;
                pend_dbz_q <= 1'b0;
                cnt_q      <= MULT_LAST;
                state_q    <= MD_RUN;
              end
              MD_DIV, MD_DIVU: begin
                pend_hi_q  <= res_hi_d;
                pend_lo_q  <= res_lo_d;
                pend_dbz_q <= dbz_d;
                cnt_q      <= DIV_LAST;
                state_q    <= MD_RUN;
              end
              MD_MTHI: hi_q <= a;
              MD_MTLO: lo_q <= a;
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // A divide by zero runs its full latency but commits nothing.
            if (!pend_dbz_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            state_q <= MD_IDLE;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == MD_RUN);
  assign done      = (state_q == MD_RUN) && (cnt_q == '0);
  assign stall_req = md_use & (busy | (start & ~flush));
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
